// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch front end: FSM states and reset constants.
package mips_pkg;
   localparam int unsigned   XLEN            = 32;
   localparam logic [31:0]   RESET_PC_DEF    = 32'h0000_0000;
   localparam logic [31:0]   NOP_INSTR       = 32'h0000_0000;
   localparam int unsigned   TIMEOUT_CYC_DEF = 16;
   localparam int unsigned   CNT_W_DEF       = 5;

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_VALID,
      S_HALT
   } fetch_state_e;
endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: jump beats branch beats sequential; flags and clears a misaligned target.
module pc_next_sel
   import mips_pkg::*;
(
   input  logic [XLEN-1:0] pc_plus4,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_addr,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic [XLEN-1:0] next_pc,
   output logic            misalign
);
   logic [XLEN-1:0] target;

   always_comb begin
      target = pc_plus4;
      if (jump) begin
         target = jump_addr;
      end else if (branch_taken) begin
         target = branch_target;
      end
   end

   assign next_pc  = {target[XLEN-1:2], 2'b00};
   assign misalign = |target[1:0];
endmodule

// File: rtl/instr_fetch_unit.sv
// PC register and req/ack fetch sequencer; holds one instruction until the datapath retires it.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        retire,
   input  logic        jump,
   input  logic [31:0] jump_addr,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        misalign,
   output logic        fetch_timeout
);
   fetch_state_e     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic             valid_q, valid_d;
   logic             req_q, req_d;
   logic             mis_q, mis_d;
   logic             tmo_q, tmo_d;
   logic [CNT_W-1:0] wdog_q, wdog_d;
   logic [CNT_W-1:0] wdog_inc;
   logic [31:0]      next_pc;
   logic             sel_mis;

   // Sequential successor wraps modulo 2^32 with no flag.
   assign pc_plus4 = pc_q + 32'd4;
   assign wdog_inc = wdog_q + CNT_W'(1);

   pc_next_sel u_pc_next_sel (
      .pc_plus4      (pc_plus4),
      .jump          (jump),
      .jump_addr     (jump_addr),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .next_pc       (next_pc),
      .misalign      (sel_mis)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
         mis_q   <= 1'b0;
         tmo_q   <= 1'b0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         req_q   <= req_d;
         mis_q   <= mis_d;
         tmo_q   <= tmo_d;
         wdog_q  <= wdog_d;
      end
   end

   // Next-state and next-output logic; req is registered from the state being entered.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      req_d   = req_q;
      mis_d   = 1'b0;
      tmo_d   = tmo_q;
      wdog_d  = wdog_q;
      case (state_q)
         S_BOOT: begin
            state_d = S_FETCH;
            req_d   = 1'b1;
         end
         S_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               wdog_d  = '0;
               req_d   = 1'b0;
               state_d = S_VALID;
            end else if (wdog_inc == CNT_W'(TIMEOUT_CYC)) begin
               wdog_d  = wdog_inc;
               tmo_d   = 1'b1;
               req_d   = 1'b0;
               state_d = S_HALT;
            end else begin
               wdog_d = wdog_inc;
            end
         end
         S_VALID: begin
            if (retire && valid_q) begin
               pc_d    = next_pc;
               valid_d = 1'b0;
               mis_d   = sel_mis;
               req_d   = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_HALT: begin
            req_d = 1'b0;
         end
         default: begin
            state_d = S_BOOT;
            req_d   = 1'b0;
         end
      endcase
   end

   assign imem_req      = req_q;
   assign imem_addr     = pc_q;
   assign pc            = pc_q;
   assign instr         = instr_q;
   assign instr_valid   = valid_q;
   assign misalign      = mis_q;
   assign fetch_timeout = tmo_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected {pc, instr} pairs are queued and popped as instructions appear.
module tb_instr_fetch_unit;
   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        retire;
   logic        jump;
   logic [31:0] jump_addr;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        misalign;
   logic        fetch_timeout;

   int          n_vec = 0;
   int          n_err = 0;
   int          mode  = 0;   // 0: zero-wait memory, 1: withhold ack, 2: bench drives ack by hand
   logic [63:0] exp_q[$];
   logic        prev_v = 1'b0;
   logic [31:0] last_addr;
   logic        last_req;
   logic        last_mis;

   instr_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .retire        (retire),
      .jump          (jump),
      .jump_addr     (jump_addr),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .misalign      (misalign),
      .fetch_timeout (fetch_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return (a == 32'h0) ? 32'h2008_0005 : (32'hC000_0000 ^ a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] epc, input logic [31:0] ein);
      exp_q.push_back({epc, ein});
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (instr_valid) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL wait_valid: instr_valid never rose within 64 cycles");
   endtask

   task automatic retire_with(input logic j, input logic [31:0] ja,
                              input logic b, input logic [31:0] bt);
      wait_valid();
      #1;
      retire = 1'b1; jump = j; jump_addr = ja; branch_taken = b; branch_target = bt;
      @(negedge clk);
      last_addr = imem_addr;
      last_req  = imem_req;
      last_mis  = misalign;
      #1;
      retire = 1'b0; jump = 1'b0; branch_taken = 1'b0;
   endtask

   // Memory responder: acks whatever is requested, sampled mid-cycle.
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         #2;
         if (mode == 0) begin
            imem_ack   = imem_req;
            imem_rdata = mem_rd(imem_addr);
         end else if (mode == 1) begin
            imem_ack = 1'b0;
         end
      end
   end

   // Monitor: every newly presented instruction must match the head of the queue.
   initial begin
      forever begin
         @(negedge clk);
         if (instr_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL sb_unexpected: pc %08h instr %08h with nothing expected", pc, instr);
            end else begin
               logic [63:0] e;
               e = exp_q.pop_front();
               check("sb_pc", pc, e[63:32]);
               check("sb_instr", instr, e[31:0]);
            end
         end
         prev_v = instr_valid;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [31:0] cnt;
      reset = 1'b1; retire = 1'b0; jump = 1'b0; jump_addr = 32'h0;
      branch_taken = 1'b0; branch_target = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_tmo", 32'(fetch_timeout), 32'd0);
      check("rst_mis", 32'(misalign), 32'd0);

      // Boot and zero-wait first fetch
      push(32'h0, 32'h2008_0005);
      #1 reset = 1'b0;
      @(negedge clk);
      check("boot_req", 32'(imem_req), 32'd1);
      check("boot_addr", imem_addr, 32'h0);
      check("boot_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check("first_valid", 32'(instr_valid), 32'd1);

      // Sequential retires; valid low exactly one cycle with zero-wait memory
      push(32'h4, 32'hC000_0004);
      retire_with(1'b0, 32'h0, 1'b0, 32'h0);
      check("seq4_addr", last_addr, 32'h4);
      check("seq4_gap", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check("seq4_back", 32'(instr_valid), 32'd1);
      push(32'h8, 32'hC000_0008);
      retire_with(1'b0, 32'h0, 1'b0, 32'h0);
      check("seq8_addr", last_addr, 32'h8);
      push(32'hC, 32'hC000_000C);
      retire_with(1'b0, 32'h0, 1'b0, 32'h0);
      push(32'h10, 32'hC000_0010);
      retire_with(1'b0, 32'h0, 1'b0, 32'h0);
      check("seq10_addr", last_addr, 32'h10);

      // Branch, then jump+branch (jump wins), then misaligned branch target
      push(32'h40, 32'hC000_0040);
      retire_with(1'b0, 32'h0, 1'b1, 32'h40);
      check("br_addr", last_addr, 32'h40);
      check("br_mis", 32'(last_mis), 32'd0);
      push(32'h100, 32'hC000_0100);
      retire_with(1'b1, 32'h100, 1'b1, 32'h200);
      check("jmp_prio_addr", last_addr, 32'h100);
      push(32'h40, 32'hC000_0040);
      retire_with(1'b0, 32'h0, 1'b1, 32'h42);
      check("mis_addr", last_addr, 32'h40);
      check("mis_pulse", 32'(last_mis), 32'd1);
      @(negedge clk);
      check("mis_drop", 32'(misalign), 32'd0);

      // PC wrap at the top of the address space
      push(32'hFFFF_FFFC, 32'h3FFF_FFFC);
      retire_with(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      check("top_addr", last_addr, 32'hFFFF_FFFC);
      wait_valid();
      check("wrap_plus4", pc_plus4, 32'h0);
      push(32'h0, 32'h2008_0005);
      retire_with(1'b0, 32'h0, 1'b0, 32'h0);
      check("wrap_addr", last_addr, 32'h0);

      // Stalled fetch: control inputs ignored while invalid, then reset with a same-cycle ack
      wait_valid();
      #1 mode = 1;
      retire_with(1'b0, 32'h0, 1'b0, 32'h0);
      check("wait_addr", last_addr, 32'h4);
      check("wait_req", 32'(last_req), 32'd1);
      retire = 1'b1; jump = 1'b1; jump_addr = 32'h300;
      @(negedge clk);
      check("ign_addr", imem_addr, 32'h4);
      check("ign_valid", 32'(instr_valid), 32'd0);
      #1;
      retire = 1'b0; jump = 1'b0;
      mode = 2; reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("rack_req", 32'(imem_req), 32'd0);
      check("rack_valid", 32'(instr_valid), 32'd0);
      check("rack_instr", instr, 32'h0);
      check("rack_pc", pc, 32'h0);
      #1;
      imem_ack = 1'b0; mode = 0;
      push(32'h0, 32'h2008_0005);
      reset = 1'b0;

      // Watchdog: sixteen unacknowledged request cycles, then halt
      wait_valid();
      #1 mode = 1;
      retire_with(1'b0, 32'h0, 1'b0, 32'h0);
      cnt = 32'(last_req);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!imem_req) break;
         cnt++;
      end
      check("wd_req_cycles", cnt, 32'd16);
      check("wd_tmo", 32'(fetch_timeout), 32'd1);
      check("wd_req_low", 32'(imem_req), 32'd0);
      #1;
      mode = 2; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      repeat (3) @(negedge clk);
      check("halt_valid", 32'(instr_valid), 32'd0);
      check("halt_instr", instr, 32'h2008_0005);
      check("halt_pc", pc, 32'h4);
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_tmo", 32'(fetch_timeout), 32'd1);
      #1;
      imem_ack = 1'b0; mode = 0; reset = 1'b1;
      @(negedge clk);
      check("clr_tmo", 32'(fetch_timeout), 32'd0);
      check("clr_pc", pc, 32'h0);
      push(32'h0, 32'h2008_0005);
      #1 reset = 1'b0;
      wait_valid();
      #2;
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
